// File: rtl/beep_sequencer.sv
// Programmable tone sequencer: CPU programs period/duration/repeat, then TONE/GAP phases run on their own.
// Optional completion interrupt is compiled in with the BEEP_IRQ_EN macro.
module beep_sequencer #(
  parameter int PRESCALE = 16,
  parameter int DUR_DIV  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [1:0] io_adr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       beep,
  output logic       busy
`ifdef BEEP_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = 8 + $clog2(DUR_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    per_lo_q, per_lo_d;
  logic [3:0]    per_hi_q, per_hi_d;
  logic [7:0]    dur_q, dur_d;
  logic [3:0]    rep_q, rep_d;
  logic          done_q, done_d;
  logic [3:0]    rep_cnt_q, rep_cnt_d;
  logic [7:0]    dur_len_q, dur_len_d;
  logic [11:0]   per_act_q, per_act_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [11:0]   half_cnt_q, half_cnt_d;
  logic [DW-1:0] dur_cnt_q, dur_cnt_d;
  logic          beep_q, beep_d;
  logic          ie_rd;

`ifdef BEEP_IRQ_EN
  logic ie_q, ie_d;
  logic unused_wdata;
  assign unused_wdata = wdata[3];
  assign ie_rd = ie_q;
`else
  logic [1:0] unused_wdata;
  assign unused_wdata = wdata[3:2];
  assign ie_rd = 1'b0;
`endif

  logic [11:0]   period;
  logic          wr_ctrl, rd_ctrl, start, stop;
  logic [DW-1:0] dur_limit;
  logic          phase_end, last_tone, tick, seq_done;

  assign period    = {per_hi_q, per_lo_q};
  assign wr_ctrl   = io_wr && (io_adr == 2'd3);
  assign rd_ctrl   = io_rd && (io_adr == 2'd3);
  assign stop      = wr_ctrl && wdata[1];
  assign start     = wr_ctrl && wdata[0] && !wdata[1];
  assign dur_limit = DW'(dur_len_q) * DW'(DUR_DIV);
  // A zero-length phase ends immediately; zero-length tones collapse the whole sequence.
  assign phase_end = (dur_len_q == 8'd0) || (dur_cnt_q == dur_limit - DW'(1));
  assign last_tone = (dur_len_q == 8'd0) || (rep_cnt_q == 4'd0);
  assign tick      = (pre_cnt_q == PW'(PRESCALE - 1));
  assign seq_done  = (state_q == S_TONE) && phase_end && last_tone && !start && !stop;

  // State register and all other flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      per_lo_q   <= 8'hFA;
      per_hi_q   <= 4'h0;
      dur_q      <= 8'h00;
      rep_q      <= 4'h0;
      done_q     <= 1'b0;
      rep_cnt_q  <= 4'h0;
      dur_len_q  <= 8'h00;
      per_act_q  <= 12'h000;
      pre_cnt_q  <= '0;
      half_cnt_q <= 12'h000;
      dur_cnt_q  <= '0;
      beep_q     <= 1'b0;
`ifdef BEEP_IRQ_EN
      ie_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      per_lo_q   <= per_lo_d;
      per_hi_q   <= per_hi_d;
      dur_q      <= dur_d;
      rep_q      <= rep_d;
      done_q     <= done_d;
      rep_cnt_q  <= rep_cnt_d;
      dur_len_q  <= dur_len_d;
      per_act_q  <= per_act_d;
      pre_cnt_q  <= pre_cnt_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      beep_q     <= beep_d;
`ifdef BEEP_IRQ_EN
      ie_q       <= ie_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_TONE:  if (phase_end) state_d = last_tone ? S_IDLE : S_GAP;
      S_GAP:   if (phase_end) state_d = S_TONE;
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_TONE;
    end
  end

  // CPU-visible register file
  always_comb begin
    per_lo_d = per_lo_q;
    per_hi_d = per_hi_q;
    dur_d    = dur_q;
    rep_d    = rep_q;
    done_d   = done_q;
`ifdef BEEP_IRQ_EN
    ie_d     = ie_q;
`endif
    if (io_wr) begin
      case (io_adr)
        2'd0: per_lo_d = wdata;
        2'd1: per_hi_d = wdata[3:0];
        2'd2: dur_d    = wdata;
        default: begin
          rep_d = wdata[7:4];
`ifdef BEEP_IRQ_EN
          ie_d  = wdata[2];
`endif
        end
      endcase
    end
    // Completion beats a same-edge clearing read.
    if (seq_done) begin
      done_d = 1'b1;
    end else if (rd_ctrl) begin
      done_d = 1'b0;
    end
  end

  // Phase, prescaler and half-period counters
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    dur_len_d  = dur_len_q;
    per_act_d  = per_act_q;
    pre_cnt_d  = pre_cnt_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    beep_d     = beep_q;
    if (stop) begin
      pre_cnt_d  = '0;
      half_cnt_d = 12'h000;
      dur_cnt_d  = '0;
      beep_d     = 1'b0;
    end else if (start) begin
      rep_cnt_d  = wdata[7:4];
      dur_len_d  = dur_q;
      per_act_d  = period;
      pre_cnt_d  = '0;
      half_cnt_d = 12'h000;
      dur_cnt_d  = '0;
      beep_d     = 1'b0;
    end else begin
      case (state_q)
        S_TONE: begin
          if (phase_end) begin
            dur_len_d  = dur_q;
            pre_cnt_d  = '0;
            half_cnt_d = 12'h000;
            dur_cnt_d  = '0;
            beep_d     = 1'b0;
          end else begin
            dur_cnt_d = dur_cnt_q + DW'(1);
            if (tick) begin
              pre_cnt_d = '0;
              // Period changes are only picked up at a half-period reload.
              if (per_act_q == 12'h000) begin
                half_cnt_d = 12'h000;
                per_act_d  = period;
              end else if (half_cnt_q == per_act_q - 12'd1) begin
                half_cnt_d = 12'h000;
                per_act_d  = period;
                beep_d     = !beep_q;
              end else begin
                half_cnt_d = half_cnt_q + 12'd1;
              end
            end else begin
              pre_cnt_d = pre_cnt_q + PW'(1);
            end
          end
        end
        S_GAP: begin
          if (phase_end) begin
            rep_cnt_d  = rep_cnt_q - 4'd1;
            dur_len_d  = dur_q;
            per_act_d  = period;
            pre_cnt_d  = '0;
            half_cnt_d = 12'h000;
            dur_cnt_d  = '0;
            beep_d     = 1'b0;
          end else begin
            dur_cnt_d = dur_cnt_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    beep = beep_q;
    case (io_adr)
      2'd0:    rdata = per_lo_q;
      2'd1:    rdata = {4'b0000, per_hi_q};
      2'd2:    rdata = dur_q;
      default: rdata = {rep_q, 1'b0, ie_rd, done_q, busy};
    endcase
`ifdef BEEP_IRQ_EN
    irq = done_q && ie_q;
`endif
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer (PRESCALE=4, DUR_DIV=64); irq checks compile in with BEEP_IRQ_EN.
module tb_beep_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [1:0] io_adr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       beep;
  logic       busy;
`ifdef BEEP_IRQ_EN
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  beep_sequencer #(.PRESCALE(4), .DUR_DIV(64)) dut (
    .clk(clk),
    .reset(reset),
    .io_wr(io_wr),
    .io_rd(io_rd),
    .io_adr(io_adr),
    .wdata(wdata),
    .rdata(rdata),
    .beep(beep),
    .busy(busy)
`ifdef BEEP_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {busy, beep} at cycle t after the START edge, from the phase arithmetic.
  function automatic logic [1:0] model(input int p, input int d, input int r, input int t);
    int len;
    int total;
    logic bz;
    logic bp;
    len   = d * 64;
    total = (d == 0) ? 1 : (2 * r + 1) * len;
    bz    = (t < total);
    bp    = 1'b0;
    if (d != 0 && p != 0 && t < total && ((t / len) % 2) == 0)
      bp = (((t % len) / (p * 4)) % 2) == 1;
    return {bz, bp};
  endfunction

  // Drivers
  task automatic wr(input logic [1:0] adr, input logic [7:0] data);
    @(negedge clk);
    io_wr  = 1'b1;
    io_adr = adr;
    wdata  = data;
    @(negedge clk);
    io_wr  = 1'b0;
  endtask

  task automatic peek(input logic [1:0] adr, input logic [7:0] exp, input string tag);
    io_adr = adr;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic rd_check(input logic [1:0] adr, input logic [7:0] exp, input string tag);
    @(negedge clk);
    io_rd  = 1'b1;
    io_adr = adr;
    #1;
    check(tag, rdata, exp);
    @(negedge clk);
    io_rd  = 1'b0;
  endtask

  task automatic program_regs(input int p, input int d);
    wr(2'd0, 8'(p));
    wr(2'd1, 8'(p >> 8));
    wr(2'd2, 8'(d));
  endtask

  task automatic start_seq(input int r);
    wr(2'd3, 8'((r << 4) | 1));
  endtask

  // Scoreboard: queue the expected waveform, then compare each cycle.
  task automatic check_seq(input int p, input int d, input int r);
    int total;
    logic [1:0] e;
    total = (d == 0) ? 1 : (2 * r + 1) * d * 64;
    for (int t = 0; t < total + 4; t++) exp_q.push_back(model(p, d, r, t));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seq_busy", busy, e[1]);
      check("seq_beep", beep, e[0]);
      @(negedge clk);
    end
    rd_check(2'd3, 8'((r << 4) | 2), "done_read");
    rd_check(2'd3, 8'(r << 4), "done_cleared");
  endtask

  initial begin
    int p;
    int d;
    int r;

    // Reset defaults
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_beep", beep, 1'b0);
    peek(2'd0, 8'hFA, "rst_per_lo");
    peek(2'd1, 8'h00, "rst_per_hi");
    peek(2'd2, 8'h00, "rst_dur");
    peek(2'd3, 8'h00, "rst_ctrl");

    // Single tone, REP=0
    program_regs(3, 2);
    check("pre_start_busy", busy, 1'b0);
    start_seq(0);
    check_seq(3, 2, 0);

    // Three bursts with gaps
    program_regs(2, 1);
    start_seq(2);
    check_seq(2, 1, 2);

    // STOP mid-tone, then START+STOP together
    program_regs(2, 2);
    start_seq(1);
    repeat (40) @(negedge clk);
    wr(2'd3, 8'h02);
    check("stop_busy", busy, 1'b0);
    check("stop_beep", beep, 1'b0);
    peek(2'd3, 8'h00, "stop_ctrl");
    wr(2'd3, 8'h03);
    repeat (5) @(negedge clk);
    check("startstop_busy", busy, 1'b0);
    check("startstop_beep", beep, 1'b0);
    peek(2'd3, 8'h00, "startstop_ctrl");

    // Zero duration and zero period
    program_regs(5, 0);
    start_seq(0);
    check_seq(5, 0, 0);
    program_regs(0, 1);
    start_seq(0);
    check_seq(0, 1, 0);

    // Restart while busy
    program_regs(1, 1);
    start_seq(1);
    repeat (30) @(negedge clk);
    start_seq(0);
    check_seq(1, 1, 0);

    // Read of CTRL on the edge DONE sets
    program_regs(1, 1);
    start_seq(0);
    repeat (63) @(negedge clk);
    io_rd  = 1'b1;
    io_adr = 2'd3;
    @(negedge clk);
    io_rd  = 1'b0;
    check("race_busy", busy, 1'b0);
    peek(2'd3, 8'h02, "race_done_kept");
    rd_check(2'd3, 8'h02, "race_read");
    peek(2'd3, 8'h00, "race_cleared");

    // Asynchronous reset mid-tone
    program_regs(3, 2);
    start_seq(0);
    repeat (14) @(negedge clk);
    check("mid_tone_beep", beep, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_beep", beep, 1'b0);
    peek(2'd0, 8'hFA, "async_per_lo");
    peek(2'd2, 8'h00, "async_dur");
    peek(2'd3, 8'h00, "async_ctrl");
    @(negedge clk);
    reset = 1'b0;

    // Randomized sequences
    repeat (8) begin
      p = $urandom_range(0, 7);
      d = $urandom_range(0, 2);
      r = $urandom_range(0, 3);
      program_regs(p, d);
      start_seq(r);
      check_seq(p, d, r);
    end

`ifdef BEEP_IRQ_EN
    // Completion interrupt enabled, then masked
    program_regs(1, 1);
    wr(2'd3, 8'h05);
    repeat (64) @(negedge clk);
    check("irq_busy", busy, 1'b0);
    check("irq_set", irq, 1'b1);
    rd_check(2'd3, 8'h06, "irq_ctrl");
    check("irq_cleared", irq, 1'b0);
    peek(2'd3, 8'h04, "irq_ctrl_after");
    wr(2'd3, 8'h01);
    repeat (64) @(negedge clk);
    check("irq_masked", irq, 1'b0);
    peek(2'd3, 8'h02, "irq_masked_done");
    rd_check(2'd3, 8'h02, "irq_masked_read");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
